// File: rtl/dnn_seq_pkg.sv
// Shared types and constants for the dnn_model run sequencer.
// State enum, default digit width and a counter-width helper.
package dnn_seq_pkg;

    localparam int W_DIGIT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GO   = 3'd1,
        WAIT = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dnn_seq_wdog.sv
// Loadable down-counter with a zero flag; serves as both the per-run
// watchdog and the inter-run gap timer. Decrement stops at zero.
module dnn_seq_wdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dnn_run_sequencer.sv
// Issues N_RUNS go pulses to dnn_model, collects each digit into resp, and
// flags a hung inference. Optional feature macro: DNN_SEQ_STRICT_EN (spurious_cnt).
//
// Handshake: go is a one-cycle request; ready is a one-cycle result strobe with
// digit valid while it is high, and is accepted only in WAIT. There is no
// back-pressure on either side.
module dnn_run_sequencer
    import dnn_seq_pkg::*;
#(
    parameter int N_RUNS      = 8,
    parameter int W_DIGIT     = W_DIGIT_DEF,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int GAP_CYC     = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    output logic                      go,
    input  logic                      ready,
    input  logic [W_DIGIT-1:0]        digit,
    output logic [N_RUNS*W_DIGIT-1:0] resp,
    output logic                      resp_valid,
    output logic                      busy,
    output logic                      timeout_err,
`ifdef DNN_SEQ_STRICT_EN
    output logic [7:0]                spurious_cnt,
`endif
    output seq_state_t                dbg_state
);

    localparam int WDOG_W = cnt_width(TIMEOUT_CYC - 1);
    localparam int GAP_W  = cnt_width(GAP_CYC);
    localparam int RUN_W  = cnt_width(N_RUNS);
    localparam bit HAS_GAP = (GAP_CYC > 0);

    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(HAS_GAP ? GAP_CYC - 1 : 0);
    localparam logic [RUN_W-1:0]  LAST_RUN  = RUN_W'(N_RUNS - 1);

    seq_state_t       state_q, state_d;
    logic [RUN_W-1:0] run_idx;

    logic seq_clear, capture, run_inc, to_set;
    logic wdog_load, wdog_dec, wdog_zero;
    logic gap_load, gap_dec, gap_zero;

    dnn_seq_wdog #(.W(WDOG_W)) u_wdog (
        .clk      (clk),
        .rstn     (rstn),
        .load     (wdog_load),
        .load_val (WDOG_LOAD),
        .dec      (wdog_dec),
        .zero     (wdog_zero)
    );

    dnn_seq_wdog #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rstn     (rstn),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    always_comb begin
        state_d   = state_q;
        seq_clear = 1'b0;
        capture   = 1'b0;
        run_inc   = 1'b0;
        to_set    = 1'b0;
        wdog_load = 1'b0;
        wdog_dec  = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    seq_clear = 1'b1;
                    state_d   = GO;
                end
            end
            GO: begin
                wdog_load = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                // A ready on the expiry cycle still counts as a good result.
                if (ready) begin
                    capture = 1'b1;
                    if (run_idx == LAST_RUN) begin
                        state_d = DONE;
                    end else begin
                        run_inc = 1'b1;
                        if (HAS_GAP) begin
                            gap_load = 1'b1;
                            state_d  = GAP;
                        end else begin
                            state_d  = GO;
                        end
                    end
                end else if (wdog_zero) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_dec = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d = GO;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            go          <= 1'b0;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            run_idx     <= '0;
            resp        <= '0;
        end else begin
            state_q    <= state_d;
            go         <= (state_d == GO);
            resp_valid <= (state_d == DONE);
            busy       <= (state_d != IDLE);
            if (seq_clear) begin
                run_idx     <= '0;
                resp        <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (to_set) begin
                    timeout_err <= 1'b1;
                end
                if (run_inc) begin
                    run_idx <= run_idx + RUN_W'(1);
                end
                if (capture) begin
                    for (int k = 0; k < N_RUNS; k++) begin
                        if (run_idx == RUN_W'(k)) begin
                            resp[k*W_DIGIT +: W_DIGIT] <= digit;
                        end
                    end
                end
            end
        end
    end

`ifdef DNN_SEQ_STRICT_EN
    // Counts ready strobes outside WAIT; saturates and only reset clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spurious_cnt <= 8'd0;
        end else if (ready && (state_q != WAIT) && (spurious_cnt != 8'hFF)) begin
            spurious_cnt <= spurious_cnt + 8'd1;
        end
    end
`else
    // Stray ready outside WAIT falls through the FSM with no effect.
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_dnn_run_sequencer.sv
// Directed self-checking bench for dnn_run_sequencer; dnn_model is played by
// run_one, which answers each go with ready after a chosen delay.
`timescale 1ns/1ps
module tb_dnn_run_sequencer;
    import dnn_seq_pkg::*;

    localparam int N_RUNS      = 8;
    localparam int W_DIGIT     = 4;
    localparam int TIMEOUT_CYC = 200;
    localparam int GAP_CYC     = 16;
    localparam int RW          = N_RUNS * W_DIGIT;

    logic               clk   = 1'b0;
    logic               rstn  = 1'b0;
    logic               start = 1'b0;
    logic               ready = 1'b0;
    logic [W_DIGIT-1:0] digit = '0;
    logic               go;
    logic [RW-1:0]      resp;
    logic               resp_valid;
    logic               busy;
    logic               timeout_err;
    seq_state_t         dbg_state;
`ifdef DNN_SEQ_STRICT_EN
    logic [7:0]         spurious_cnt;
`endif

    int err_cnt   = 0;
    int chk_cnt   = 0;
    int cyc       = 0;
    int go_pulses = 0;
    int rv_pulses = 0;
    int gc, rc, prev_r, g0, v0, t;

    logic [RW-1:0]      exp_q[$];
    logic [W_DIGIT-1:0] dig6 [8] = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6};

    dnn_run_sequencer #(
        .N_RUNS      (N_RUNS),
        .W_DIGIT     (W_DIGIT),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .go           (go),
        .ready        (ready),
        .digit        (digit),
        .resp         (resp),
        .resp_valid   (resp_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
`ifdef DNN_SEQ_STRICT_EN
        .spurious_cnt (spurious_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every resp_valid must match the next expected word
    always @(negedge clk) begin
        if (rstn && go) go_pulses++;
        if (rstn && resp_valid) begin
            rv_pulses++;
            if (exp_q.size() == 0) check("rv_unexpected", 32'(resp_valid), 0);
            else check("resp_word", resp, exp_q.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_go(output int go_c);
        int waited;
        waited = 0;
        while (!go && waited < 64) begin
            step(1);
            waited++;
        end
        if (!go) check("go_wait", 32'(go), 1);
        go_c = cyc;
    endtask

    // dnn_model stand-in: ready with dig exactly d cycles after go
    task automatic run_one(input logic [W_DIGIT-1:0] dig, input int d,
                           output int go_c, output int rdy_c);
        wait_go(go_c);
        step(d);
        ready = 1'b1;
        digit = dig;
        rdy_c = cyc;
        step(1);
        ready = 1'b0;
    endtask

    initial begin
        // reset state
        step(2);
        check("rst_go", 32'(go), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_resp", resp, 0);
        check("rst_rv", 32'(resp_valid), 0);
        check("rst_terr", 32'(timeout_err), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rstn = 1'b1;
        step(2);

        // full sequence, digits 0..7, 17-cycle ready-to-go spacing
        exp_q.push_back(32'h7654_3210);
        g0 = go_pulses;
        v0 = rv_pulses;
        do_start();
        check("t1_go_after_start", 32'(go), 1);
        check("t1_busy", 32'(busy), 1);
        prev_r = 0;
        for (int k = 0; k < N_RUNS; k++) begin
            run_one(4'(k), 100, gc, rc);
            if (k > 0) check("t1_gap", 32'(gc - prev_r), 17);
            prev_r = rc;
        end
        check("t1_rv_after_last", 32'(resp_valid), 1);
        step(1);
        check("t1_rv_one_cycle", 32'(resp_valid), 0);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_go_count", 32'(go_pulses - g0), 8);
        check("t1_rv_count", 32'(rv_pulses - v0), 1);
        step(3);

        // run 3 hangs: watchdog fires on its 200th WAIT cycle
        g0 = go_pulses;
        v0 = rv_pulses;
        do_start();
        run_one(4'hA, 50, gc, rc);
        run_one(4'hB, 50, gc, rc);
        run_one(4'hC, 50, gc, rc);
        wait_go(gc);
        t = 0;
        while (!timeout_err && t < 400) begin
            step(1);
            t++;
        end
        check("t3_timeout_latency", 32'(cyc - gc), 201);
        check("t3_timeout_flag", 32'(timeout_err), 1);
        check("t3_busy", 32'(busy), 0);
        check("t3_resp_partial", resp, 32'h0000_0CBA);
        step(5);
        check("t3_terr_sticky", 32'(timeout_err), 1);
        check("t3_no_rv", 32'(rv_pulses - v0), 0);
        check("t3_go_count", 32'(go_pulses - g0), 4);

        // start and ready injected during GAP are ignored
        exp_q.push_back(32'h8765_4321);
        g0 = go_pulses;
        v0 = rv_pulses;
        do_start();
        check("t4_terr_cleared", 32'(timeout_err), 0);
        run_one(4'h1, 30, gc, rc);
        prev_r = rc;
        step(3);
        ready = 1'b1;
        digit = 4'hF;
        step(1);
        ready = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t4_state_gap", 32'(dbg_state), 32'(GAP));
        check("t4_resp_unchanged", resp, 32'h0000_0001);
        for (int k = 1; k < N_RUNS; k++) begin
            run_one(4'(k + 1), 30, gc, rc);
            check("t4_gap", 32'(gc - prev_r), 17);
            prev_r = rc;
        end
        step(2);
        check("t4_go_count", 32'(go_pulses - g0), 8);
        check("t4_rv_count", 32'(rv_pulses - v0), 1);
`ifdef DNN_SEQ_STRICT_EN
        check("t4_spurious", 32'(spurious_cnt), 1);
`endif

        // reset during WAIT of run 5, then a clean full sequence
        do_start();
        for (int k = 0; k < 5; k++) run_one(4'(k + 1), 20, gc, rc);
        wait_go(gc);
        step(10);
        rstn = 1'b0;
        #1;
        check("t5_rst_go", 32'(go), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_resp", resp, 0);
        check("t5_rst_rv", 32'(resp_valid), 0);
        check("t5_rst_terr", 32'(timeout_err), 0);
        check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef DNN_SEQ_STRICT_EN
        check("t5_rst_spurious", 32'(spurious_cnt), 0);
`endif
        step(2);
        rstn = 1'b1;
        step(2);
        check("t5_idle_after_rst", 32'(busy), 0);
        exp_q.push_back(32'hFEDC_BA98);
        g0 = go_pulses;
        v0 = rv_pulses;
        do_start();
        for (int k = 0; k < N_RUNS; k++) run_one(4'(k + 8), 5, gc, rc);
        step(2);
        check("t5_go_count", 32'(go_pulses - g0), 8);
        check("t5_rv_count", 32'(rv_pulses - v0), 1);
        check("t5_busy_done", 32'(busy), 0);

        // ready lands on the watchdog-expiry cycle of every run
        exp_q.push_back(32'h6295_1413);
        v0 = rv_pulses;
        do_start();
        run_one(dig6[0], TIMEOUT_CYC, gc, rc);
        check("t6_no_timeout", 32'(timeout_err), 0);
        check("t6_busy", 32'(busy), 1);
        check("t6_state_gap", 32'(dbg_state), 32'(GAP));
        for (int k = 1; k < N_RUNS; k++) run_one(dig6[k], TIMEOUT_CYC, gc, rc);
        check("t6_rv_after_last", 32'(resp_valid), 1);
        step(2);
        check("t6_terr_final", 32'(timeout_err), 0);
        check("t6_rv_count", 32'(rv_pulses - v0), 1);
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
